// File: rtl/otter_pkg.sv
// Shared types for the OTTER pipeline front end.
package otter_pkg;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] ir;
   } fetch_entry_t;

   localparam int INSTR_BYTES = 4;

endpackage

// File: rtl/otter_fetch_fifo.sv
// Circular buffer of fetched {pc, ir} entries; wrap-bit pointers give full/empty without a spare slot.
module otter_fetch_fifo
   import otter_pkg::*;
#(
   parameter int DEPTH = 2
)(
   input  logic                     CLK,
   input  logic                     RESET_N,
   input  logic                     clr,
   input  logic                     push,
   input  fetch_entry_t             push_data,
   input  logic                     pop,
   output fetch_entry_t             head,
   output logic                     not_empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);

   fetch_entry_t     mem [DEPTH];
   logic [PTR_W:0]   wr_ptr;
   logic [PTR_W:0]   rd_ptr;

   assign count     = wr_ptr - rd_ptr;
   assign not_empty = (wr_ptr != rd_ptr);
   assign head      = mem[rd_ptr[PTR_W-1:0]];

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop && not_empty)
            rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage needs no reset: entries are only observed behind not_empty.
   always_ff @(posedge CLK) begin
      if (push && !clr)
         mem[wr_ptr[PTR_W-1:0]] <= push_data;
   end

endmodule

// File: rtl/otter_fetch_stage.sv
// OTTER instruction fetch: owns the PC, issues reads on memory port 1 and hands {pc, ir, pc+4} to decode.
// Handshake: an entry transfers on a rising edge where IF_DE_VALID and DE_READY are both high; while
// IF_DE_VALID is high and DE_READY low the IF_DE_* outputs hold; DE_READY is ignored when IF_DE_VALID is low.
module otter_fetch_stage
   import otter_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2,
   parameter int          ADDR_W   = 14
)(
   input  logic              CLK,
   input  logic              RESET_N,
   output logic              MEM_RDEN1,
   output logic [ADDR_W-1:0] MEM_ADDR1,
   input  logic [31:0]       MEM_DOUT1,
   input  logic              REDIRECT,
   input  logic [31:0]       REDIRECT_PC,
   input  logic              DE_READY,
   output logic              IF_DE_VALID,
   output logic [31:0]       IF_DE_PC,
   output logic [31:0]       IF_DE_IR,
   output logic [31:0]       IF_DE_PC_INC,
   output fetch_state_t      DBG_STATE
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W+1:0] DEPTH_L = DEPTH[PTR_W+1:0];

   fetch_state_t   state;
   logic [31:0]    fetch_pc;
   logic           inflight;
   logic [31:0]    inflight_pc;
   logic [PTR_W:0] count;
   logic           head_valid;
   fetch_entry_t   head;
   fetch_entry_t   push_entry;
   logic           pop;
   logic           push;
   logic           resp_kill;
   logic           issue;
   logic [PTR_W+1:0] occ;

   assign pop        = head_valid & DE_READY;
   // A redirect kills the response landing this cycle; none can land next cycle since nothing issues now.
   assign resp_kill  = REDIRECT;
   assign push       = inflight & ~resp_kill;
   assign push_entry = '{pc: inflight_pc, ir: MEM_DOUT1};

   // Slots already held plus the one in flight, less the one leaving: issue only when a slot remains.
   assign occ   = {1'b0, count} + {{(PTR_W+1){1'b0}}, inflight} - {{(PTR_W+1){1'b0}}, pop};
   assign issue = (state != BOOT) & ~REDIRECT & (occ < DEPTH_L);

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state       <= BOOT;
         fetch_pc    <= RESET_PC;
         inflight    <= 1'b0;
         inflight_pc <= '0;
      end else begin
         inflight <= issue;
         if (issue) begin
            inflight_pc <= fetch_pc;
            fetch_pc    <= fetch_pc + 32'(INSTR_BYTES);
         end
         if (REDIRECT)
            fetch_pc <= {REDIRECT_PC[31:2], 2'b00};
         case (state)
            BOOT:    state <= RUN;
            RUN:     if (REDIRECT) state <= FLUSH;
            FLUSH:   state <= REDIRECT ? FLUSH : RUN;
            default: state <= BOOT;
         endcase
      end
   end

   otter_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .CLK       (CLK),
      .RESET_N   (RESET_N),
      .clr       (REDIRECT),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .head      (head),
      .not_empty (head_valid),
      .count     (count)
   );

   assign MEM_RDEN1    = issue;
   assign MEM_ADDR1    = fetch_pc[ADDR_W+1:2];
   assign IF_DE_VALID  = head_valid;
   assign IF_DE_PC     = head_valid ? head.pc : '0;
   assign IF_DE_IR     = head_valid ? head.ir : '0;
   assign IF_DE_PC_INC = head_valid ? head.pc + 32'(INSTR_BYTES) : '0;
   assign DBG_STATE    = state;

endmodule

// File: tb/tb_otter_fetch_stage.sv
// Bench for otter_fetch_stage: word-addressed memory model, expected-PC queue checked on every decode accept.
module tb_otter_fetch_stage;
   import otter_pkg::*;

   logic         CLK = 1'b0;
   logic         RESET_N;
   logic         MEM_RDEN1;
   logic [13:0]  MEM_ADDR1;
   logic [31:0]  MEM_DOUT1;
   logic         REDIRECT;
   logic [31:0]  REDIRECT_PC;
   logic         DE_READY;
   logic         IF_DE_VALID;
   logic [31:0]  IF_DE_PC;
   logic [31:0]  IF_DE_IR;
   logic [31:0]  IF_DE_PC_INC;
   fetch_state_t DBG_STATE;

   int n_cmp = 0;
   int n_err = 0;
   logic [31:0] exp_q[$];

   otter_fetch_stage #(.RESET_PC(32'h0), .DEPTH(2), .ADDR_W(14)) dut (
      .CLK          (CLK),
      .RESET_N      (RESET_N),
      .MEM_RDEN1    (MEM_RDEN1),
      .MEM_ADDR1    (MEM_ADDR1),
      .MEM_DOUT1    (MEM_DOUT1),
      .REDIRECT     (REDIRECT),
      .REDIRECT_PC  (REDIRECT_PC),
      .DE_READY     (DE_READY),
      .IF_DE_VALID  (IF_DE_VALID),
      .IF_DE_PC     (IF_DE_PC),
      .IF_DE_IR     (IF_DE_IR),
      .IF_DE_PC_INC (IF_DE_PC_INC),
      .DBG_STATE    (DBG_STATE)
   );

   // ---------------- clock / watchdog ----------------
   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------- memory model ----------------
   function automatic logic [31:0] mem_word(input logic [13:0] a);
      return {2'b10, a, 2'b01, ~a};
   endfunction

   always @(posedge CLK) begin
      if (MEM_RDEN1) MEM_DOUT1 <= mem_word(MEM_ADDR1);
      else           MEM_DOUT1 <= $urandom;
   end

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic push_stream(input logic [31:0] base);
      exp_q.delete();
      for (int i = 0; i < 400; i++) exp_q.push_back(base + 32'(4 * i));
   endtask

   // Scoreboard: every accepted entry must be the next expected PC with its memory word.
   logic        prev_hold = 1'b0;
   logic [31:0] prev_pc, prev_ir;

   always @(negedge CLK) begin
      if (!RESET_N) begin
         prev_hold = 1'b0;
      end else begin
         if (prev_hold && !REDIRECT) begin
            chk("hold_valid", 32'(IF_DE_VALID), 32'd1);
            chk("hold_pc", IF_DE_PC, prev_pc);
            chk("hold_ir", IF_DE_IR, prev_ir);
         end
         if (!REDIRECT && IF_DE_VALID && DE_READY) begin
            if (exp_q.size() == 0) begin
               chk("sb_empty", IF_DE_PC, 32'hDEAD_BEEF);
            end else begin
               logic [31:0] e;
               e = exp_q.pop_front();
               chk("sb_pc", IF_DE_PC, e);
               chk("sb_ir", IF_DE_IR, mem_word(e[15:2]));
               chk("sb_pc_inc", IF_DE_PC_INC, e + 32'd4);
            end
         end
         prev_hold = IF_DE_VALID && !DE_READY && !REDIRECT;
         prev_pc   = IF_DE_PC;
         prev_ir   = IF_DE_IR;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic cyc();
      @(posedge CLK);
      #2;
   endtask

   task automatic redirect_to(input logic [31:0] target);
      REDIRECT    = 1'b1;
      REDIRECT_PC = target;
      push_stream({target[31:2], 2'b00});
   endtask

   // ---------------- stimulus ----------------
   initial begin
      RESET_N     = 1'b0;
      REDIRECT    = 1'b0;
      REDIRECT_PC = '0;
      DE_READY    = 1'b1;
      repeat (3) cyc();

      // reset state
      chk("rst_valid", 32'(IF_DE_VALID), 32'd0);
      chk("rst_rden", 32'(MEM_RDEN1), 32'd0);
      chk("rst_addr", 32'(MEM_ADDR1), 32'd0);
      chk("rst_pc", IF_DE_PC, 32'd0);
      chk("rst_pc_inc", IF_DE_PC_INC, 32'd0);
      chk("rst_state", 32'(DBG_STATE), 32'(BOOT));

      // 1: sequential fetch from reset
      push_stream(32'h0);
      RESET_N = 1'b1;
      cyc();
      chk("t1_state", 32'(DBG_STATE), 32'(RUN));
      chk("t1_rden", 32'(MEM_RDEN1), 32'd1);
      chk("t1_addr0", 32'(MEM_ADDR1), 32'd0);
      cyc();
      chk("t1_addr1", 32'(MEM_ADDR1), 32'd1);
      chk("t1_notvalid", 32'(IF_DE_VALID), 32'd0);
      cyc();
      chk("t1_addr2", 32'(MEM_ADDR1), 32'd2);
      chk("t1_valid", 32'(IF_DE_VALID), 32'd1);
      chk("t1_pc0", IF_DE_PC, 32'h0);
      cyc();
      chk("t1_pc4", IF_DE_PC, 32'h4);
      cyc();
      chk("t1_pc8", IF_DE_PC, 32'h8);

      // 2: decode stall at 0x8
      DE_READY = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk("t2_hold_pc", IF_DE_PC, 32'h8);
         chk("t2_no_issue", 32'(MEM_RDEN1), 32'd0);
      end
      DE_READY = 1'b1;
      cyc();
      chk("t2_pc_c", IF_DE_PC, 32'hC);
      cyc();
      chk("t2_pc_10", IF_DE_PC, 32'h10);

      // 3: redirect with a full buffer
      DE_READY = 1'b0;
      repeat (3) cyc();
      redirect_to(32'h100);
      cyc();
      REDIRECT = 1'b0;
      DE_READY = 1'b1;
      #1;
      chk("t3_valid_drop", 32'(IF_DE_VALID), 32'd0);
      chk("t3_state", 32'(DBG_STATE), 32'(FLUSH));
      chk("t3_rden", 32'(MEM_RDEN1), 32'd1);
      chk("t3_addr", 32'(MEM_ADDR1), 32'h40);
      cyc();
      chk("t3_valid_t2", 32'(IF_DE_VALID), 32'd0);
      cyc();
      chk("t3_valid_t3", 32'(IF_DE_VALID), 32'd1);
      chk("t3_pc", IF_DE_PC, 32'h100);
      repeat (3) cyc();

      // 4: back-to-back redirects, only the second target may appear
      redirect_to(32'h200);
      exp_q.delete();
      cyc();
      redirect_to(32'h300);
      cyc();
      REDIRECT = 1'b0;
      #1;
      chk("t4_valid_drop", 32'(IF_DE_VALID), 32'd0);
      chk("t4_addr", 32'(MEM_ADDR1), 32'hC0);
      cyc();
      chk("t4_valid_t2", 32'(IF_DE_VALID), 32'd0);
      cyc();
      chk("t4_pc", IF_DE_PC, 32'h300);
      chk("t4_ir", IF_DE_IR, mem_word(14'hC0));
      repeat (3) cyc();

      // 5: unaligned target and PC wrap
      redirect_to(32'h103);
      cyc();
      REDIRECT = 1'b0;
      repeat (2) cyc();
      chk("t5_pc", IF_DE_PC, 32'h100);
      chk("t5_pc_inc", IF_DE_PC_INC, 32'h104);
      redirect_to(32'hFFFF_FFFC);
      cyc();
      REDIRECT = 1'b0;
      repeat (2) cyc();
      chk("t5_wrap_pc", IF_DE_PC, 32'hFFFF_FFFC);
      chk("t5_wrap_inc", IF_DE_PC_INC, 32'h0);
      cyc();
      chk("t5_wrap_next", IF_DE_PC, 32'h0);

      // 6: asynchronous reset mid-stall
      DE_READY = 1'b0;
      repeat (4) cyc();
      @(negedge CLK);
      #1;
      RESET_N = 1'b0;
      #1;
      chk("t6_async_valid", 32'(IF_DE_VALID), 32'd0);
      chk("t6_async_addr", 32'(MEM_ADDR1), 32'd0);
      chk("t6_async_state", 32'(DBG_STATE), 32'(BOOT));
      repeat (2) cyc();
      push_stream(32'h0);
      DE_READY = 1'b1;
      RESET_N  = 1'b1;
      repeat (3) cyc();
      chk("t6_first_pc", IF_DE_PC, 32'h0);
      chk("t6_first_ir", IF_DE_IR, mem_word(14'h0));

      // random stalls and redirects
      for (int i = 0; i < 400; i++) begin
         cyc();
         DE_READY = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 19) == 0)
            redirect_to($urandom);
         else
            REDIRECT = 1'b0;
      end
      REDIRECT = 1'b0;
      DE_READY = 1'b1;
      repeat (10) cyc();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
